// File: rtl/pwm_carrier_gen.sv
// -----------------------------------------------------------------------------
// pwm_carrier_gen
//
// Carrier counter feeding the PWM compare stage. Generates an up sawtooth,
// down sawtooth or triangle ramp between 0 and a shadowed peak value, plus
// zero/peak event decodes and the maskevent strobe the compare stage uses to
// update its own shadow registers at period boundaries.
//
// Period and mode are shadowed: software writes land in the shadows only
// while parked, on a resync, or at a period boundary. This means a
// mid-ramp write never produces a truncated or stretched carrier period.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   pwm_onoff   1 = carrier runs, 0 = carrier parked at the load value
//   period      carrier peak value P (shadowed)
//   init_carr   start / resync load value (clamped to period)
//   carr_mode   00 up saw, 01 down saw, 10 triangle, 11 hold (shadowed)
//   mask_sel    bit0 = maskevent on zero, bit1 = maskevent on peak
//   sync_in     single-cycle resync strobe (ignored while parked)
//   carrier     carrier value
//   dir         1 = counting up, 0 = counting down
//   zero_evt    carrier == 0 while running
//   period_evt  carrier == period_sh while running
//   maskevent   event selected by mask_sel
// -----------------------------------------------------------------------------
module pwm_carrier_gen #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pwm_onoff,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic [CNT_WIDTH-1:0] init_carr,
  input  logic [1:0]           carr_mode,
  input  logic [1:0]           mask_sel,
  input  logic                 sync_in,
  output logic [CNT_WIDTH-1:0] carrier,
  output logic                 dir,
  output logic                 zero_evt,
  output logic                 period_evt,
  output logic                 maskevent
);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_TRI  = 2'b10,
    MODE_HOLD = 2'b11
  } mode_t;

  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] ZERO = '0;

  // Registered state
  logic [CNT_WIDTH-1:0] carrier_reg;
  logic                 dir_reg;
  logic [CNT_WIDTH-1:0] period_sh_reg;
  mode_t                mode_sh_reg;
  // Cleared by reset, set on the first edge afterwards. Until it is set the
  // block behaves as parked, so counting after reset restarts from the load
  // value and no events are flagged while reset is (or just was) asserted.
  logic                 armed_reg;

  // Next-state signals
  logic [CNT_WIDTH-1:0] carrier_next;
  logic                 dir_next;
  logic                 shadow_load;

  // Helpers
  mode_t                mode_in;
  logic [CNT_WIDTH-1:0] load_val;
  logic                 parked;
  logic                 boundary;
  logic                 evt_enable;

  assign mode_in  = mode_t'(carr_mode);
  // Load value is clamped against the incoming (not shadowed) period, since
  // every load also refreshes the shadow with that same period.
  assign load_val = (init_carr < period) ? init_carr : period;
  assign parked   = !pwm_onoff || !armed_reg;

  // Period boundary of the currently active (shadowed) mode. A triangle
  // boundary is the bottom of the down ramp, so a triangle started at 0 with
  // dir = 1 runs a full up/down cycle before its first boundary.
  always_comb begin
    boundary = 1'b0;
    case (mode_sh_reg)
      MODE_UP:   boundary = (carrier_reg == period_sh_reg);
      MODE_DOWN: boundary = (carrier_reg == ZERO);
      MODE_TRI:  boundary = (carrier_reg == ZERO) && !dir_reg;
      default:   boundary = 1'b0;
    endcase
  end

  // Next carrier / direction
  always_comb begin
    carrier_next = carrier_reg;
    dir_next     = dir_reg;
    shadow_load  = 1'b0;

    if (parked) begin
      // Parked: track the inputs so enabling starts cleanly from L.
      shadow_load  = 1'b1;
      carrier_next = load_val;
      dir_next     = (mode_in != MODE_DOWN);
    end else if (sync_in) begin
      // Resync wins over the boundary rule. A triangle loaded at its peak
      // must head down, otherwise it would overshoot the peak.
      shadow_load  = 1'b1;
      carrier_next = load_val;
      dir_next     = !((mode_in == MODE_DOWN) ||
                       ((mode_in == MODE_TRI) && (load_val == period)));
    end else if (boundary) begin
      // Boundary: shadows refresh and the next value already uses them.
      shadow_load = 1'b1;
      if (mode_in != mode_sh_reg) begin
        // Mode change restarts the new ramp from its natural start point.
        case (mode_in)
          MODE_UP, MODE_TRI: begin
            carrier_next = ZERO;
            dir_next     = 1'b1;
          end
          MODE_DOWN: begin
            carrier_next = period;
            dir_next     = 1'b0;
          end
          default: begin
            carrier_next = carrier_reg;
            dir_next     = dir_reg;
          end
        endcase
      end else begin
        case (mode_sh_reg)
          MODE_UP: begin
            carrier_next = ZERO;
            dir_next     = 1'b1;
          end
          MODE_DOWN: begin
            carrier_next = period;
            dir_next     = 1'b0;
          end
          MODE_TRI: begin
            // With a zero peak the triangle degenerates to a constant 0
            // and the direction is left alone.
            if (period != ZERO) begin
              carrier_next = ONE;
              dir_next     = 1'b1;
            end
          end
          default: begin
            carrier_next = carrier_reg;
            dir_next     = dir_reg;
          end
        endcase
      end
    end else begin
      case (mode_sh_reg)
        MODE_UP: begin
          carrier_next = carrier_reg + ONE;
        end
        MODE_DOWN: begin
          carrier_next = carrier_reg - ONE;
        end
        MODE_TRI: begin
          if (dir_reg) begin
            if (carrier_reg == period_sh_reg) begin
              // Peak shown for exactly one cycle, then turn around.
              if (period_sh_reg != ZERO) begin
                carrier_next = period_sh_reg - ONE;
                dir_next     = 1'b0;
              end
            end else begin
              carrier_next = carrier_reg + ONE;
            end
          end else begin
            // carrier_reg != 0 here, otherwise this was a boundary.
            carrier_next = carrier_reg - ONE;
          end
        end
        default: begin
          carrier_next = carrier_reg;
          dir_next     = dir_reg;
        end
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carrier_reg   <= '0;
      dir_reg       <= 1'b1;
      period_sh_reg <= '0;
      mode_sh_reg   <= MODE_UP;
      armed_reg     <= 1'b0;
    end else begin
      carrier_reg <= carrier_next;
      dir_reg     <= dir_next;
      armed_reg   <= 1'b1;
      if (shadow_load) begin
        period_sh_reg <= period;
        mode_sh_reg   <= mode_in;
      end
    end
  end

  // Events decode the registered carrier directly, so they line up with the
  // carrier value they describe. Hold mode and parked cycles flag nothing.
  assign evt_enable = pwm_onoff && armed_reg && (mode_sh_reg != MODE_HOLD);

  assign carrier    = carrier_reg;
  assign dir        = dir_reg;
  assign zero_evt   = evt_enable && (carrier_reg == ZERO);
  assign period_evt = evt_enable && (carrier_reg == period_sh_reg);
  assign maskevent  = (zero_evt && mask_sel[0]) || (period_evt && mask_sel[1]);

endmodule

// File: doc/pwm_carrier_gen.md
Name: pwm_carrier_gen

Overview:
- Carrier counter stage directly upstream of the PWM compare stage.
- Produces the carrier ramp (up sawtooth, down sawtooth or triangle) that the compare stage compares against its masked compare value.
- Also produces the maskevent strobe that lets the compare stage's shadow registers update at period boundaries.
- Period and mode are shadowed internally, so software writes take effect only at a period boundary.

Parameters:
- CNT_WIDTH, 16, carrier/period width; equals PWMCOUNT_WIDTH.

Ports:
- clk  in  1  system clock
- reset  in  1  system reset; asynchronous, active-high
- pwm_onoff  in  1  1 = carrier runs, 0 = carrier parked
- period  in  CNT_WIDTH  carrier peak value P (shadowed)
- init_carr  in  CNT_WIDTH  start/sync load value
- carr_mode  in  2  00 up sawtooth, 01 down sawtooth, 10 triangle, 11 hold (shadowed)
- mask_sel  in  2  bit0 = maskevent on zero, bit1 = maskevent on peak
- sync_in  in  1  single-cycle resync strobe
- carrier  out  CNT_WIDTH  carrier value
- dir  out  1  1 = counting up, 0 = counting down
- zero_evt  out  1  high in cycles where the carrier equals 0 while running
- period_evt  out  1  high in cycles where the carrier equals period_sh while running
- maskevent  out  1  (zero_evt & mask_sel[0]) | (period_evt & mask_sel[1])

Behaviour:
- Reset (async, immediate):
  - carrier = 0, dir = 1.
  - period_sh = 0, mode_sh = 00.
  - zero_evt, period_evt and maskevent all 0.
- Effective load value L = min(init_carr, period), using the incoming period.
- pwm_onoff = 0 (parked):
  - Shadows follow the inputs every cycle.
  - carrier loads L each cycle.
  - dir = 0 if carr_mode = 01, else 1.
  - All event outputs are 0.
- pwm_onoff 0→1: the first running cycle presents L; counting advances from the following edge.
- Running, sawtooth modes:
  - Up (00): carrier+1 each cycle; at carrier == period_sh the next value is 0. Period = P+1 cycles.
  - Down (01): carrier−1 each cycle; at carrier == 0 the next value is the incoming period. Period = P+1 cycles.
- Running, triangle (10):
  - dir=1: increment; at carrier == period_sh, next = P−1 and dir = 0.
  - dir=0: decrement; at carrier == 0, next = 1 and dir = 1.
  - Period = 2P cycles; peak and zero are each presented for exactly 1 cycle.
- Running, hold (11): carrier and dir frozen; events 0.
- Boundary cycle definition:
  - Up: carrier == period_sh.
  - Down: carrier == 0.
  - Triangle: carrier == 0 && dir == 0.
  - At a boundary, period_sh and mode_sh load from the inputs on the same edge, and the next-value computation uses the new values.
  - A mode change at a boundary restarts the new mode from 0 (up/triangle, dir = 1) or from P (down, dir = 0).
  - The first triangle boundary after a start at 0 occurs at the end of its down ramp.
- period_sh = 0:
  - carrier stays at 0.
  - zero_evt and period_evt are both high every running cycle.
  - Triangle never toggles dir.
- sync_in while running:
  - Takes priority over the boundary rule; shadows load.
  - Next carrier = L.
  - dir = 1, except down mode or (triangle and L == period), which give dir = 0.
- sync_in while parked has no effect.
- Events are combinational decodes of the registered carrier/shadows and are aligned to the carrier value they describe (zero added latency).
- Reset asserted mid-count clears all state immediately.
- Counting resumes from L only after reset deasserts and pwm_onoff is high.

Test Plan:
- Up mode, P=4, init=0, mask_sel=01:
  - Carrier sequence 0,1,2,3,4,0,1…
  - zero_evt and maskevent high exactly when carrier = 0, every 5 cycles.
- Triangle, P=3, mask_sel=10:
  - Carrier sequence 0,1,2,3,2,1,0,1…
  - dir falls in the cycle after the 3.
  - period_evt and maskevent high every 6 cycles, at carrier 3.
- Period write mid-ramp in up mode, P 8→2 written at carrier = 3:
  - Count continues 4…8, then 0,1,2,0.
  - The new period applies only after the wrap.
- Down mode, P=5, init=9:
  - Parked carrier = 5 (clamped).
  - On enable: 5,4,3,2,1,0,5…
  - Writing carr_mode = 00 mid-ramp switches to an up ramp from 0 only after the carrier reaches 0.
- P=0 in all three modes:
  - carrier constant 0.
  - zero_evt and period_evt high every running cycle; dir constant.
- Edge cases:
  - sync_in pulse at carrier = 2 in triangle (P=6, init=4): next carrier = 4, dir = 1.
  - Reset pulse mid-count: carrier = 0 and events = 0 immediately (asynchronously).
  - pwm_onoff = 0 parks the carrier at L with no events.
